// File: rtl/axis_burst_split.sv
// AXI-Stream burst splitter: cuts packets into chunks of at most length_i beats,
// marking chunk ends on m_tlast and true packet ends on m_tend, via a skid-buffered output.
module axis_burst_split #(
  parameter int WIDTH  = 8,
  parameter int MAXLEN = 64,
  parameter int BYPASS = 0,
  localparam int LBITS = $clog2(MAXLEN + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_i,
  input  logic [LBITS-1:0] length_i,
  output logic             busy_o,
  output logic             chunk_o,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             m_tend,
  output logic [WIDTH-1:0] m_tdata
);

  generate
    if (BYPASS != 0) begin : g_bypass
      assign m_tvalid = s_tvalid;
      assign m_tdata  = s_tdata;
      assign m_tlast  = s_tlast;
      assign m_tend   = s_tlast;
      assign s_tready = m_tready;
      assign busy_o   = 1'b0;
      assign chunk_o  = 1'b0;
    end else begin : g_split
      // Beat word layout: {data, chunk_end, packet_end}
      logic [WIDTH+1:0] out_reg, out_next, skid_reg, skid_next, beat;
      logic             out_valid_reg, out_valid_next;
      logic             skid_valid_reg, skid_valid_next;
      logic [LBITS-1:0] cnt_reg, cnt_next, cnt_val, len_eff;
      logic             bnd_reg, bnd_next;
      logic             busy_reg, busy_next;
      logic             ready_reg, ready_next;
      logic             chunk_reg, chunk_next;
      logic             accept, beat_end, load_out;

      always_comb begin
        len_eff = (length_i == '0 || length_i > LBITS'(MAXLEN)) ? LBITS'(MAXLEN) : length_i;
        cnt_val = bnd_reg ? (len_eff - LBITS'(1)) : (cnt_reg - LBITS'(1));
        beat_end = (cnt_val == '0) || s_tlast;
        beat     = {s_tdata, beat_end, s_tlast};
        accept   = s_tvalid && ready_reg;
        load_out = !out_valid_reg || m_tready;

        cnt_next        = cnt_reg;
        bnd_next        = bnd_reg;
        busy_next       = busy_reg;
        out_next        = out_reg;
        out_valid_next  = out_valid_reg;
        skid_next       = skid_reg;
        skid_valid_next = skid_valid_reg;

        if (accept) begin
          cnt_next  = cnt_val;
          bnd_next  = beat_end;
          busy_next = !beat_end;
        end

        // Skid beat is older than any source beat, so it always drains first.
        if (load_out) begin
          if (skid_valid_reg) begin
            out_next        = skid_reg;
            out_valid_next  = 1'b1;
            skid_valid_next = accept;
            if (accept) skid_next = beat;
          end else if (accept) begin
            out_next       = beat;
            out_valid_next = 1'b1;
          end else begin
            out_valid_next = 1'b0;
          end
        end else if (accept) begin
          skid_next       = beat;
          skid_valid_next = 1'b1;
        end

        // Ready looks at next-state so it is never high while the skid holds a beat.
        ready_next = !skid_valid_next && !(bnd_next && !enable_i);
        chunk_next = out_valid_reg && m_tready && out_reg[1];
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          out_reg        <= '0;
          out_valid_reg  <= 1'b0;
          skid_reg       <= '0;
          skid_valid_reg <= 1'b0;
          cnt_reg        <= '0;
          bnd_reg        <= 1'b1;
          busy_reg       <= 1'b0;
          ready_reg      <= 1'b0;
          chunk_reg      <= 1'b0;
        end else begin
          out_reg        <= out_next;
          out_valid_reg  <= out_valid_next;
          skid_reg       <= skid_next;
          skid_valid_reg <= skid_valid_next;
          cnt_reg        <= cnt_next;
          bnd_reg        <= bnd_next;
          busy_reg       <= busy_next;
          ready_reg      <= ready_next;
          chunk_reg      <= chunk_next;
        end
      end

      assign m_tvalid = out_valid_reg;
      assign m_tdata  = out_reg[WIDTH+1:2];
      assign m_tlast  = out_reg[1];
      assign m_tend   = out_reg[0];
      assign s_tready = ready_reg;
      assign busy_o   = busy_reg;
      assign chunk_o  = chunk_reg;
    end
  endgenerate

endmodule

// File: tb/tb_axis_burst_split.sv
// Directed bench for axis_burst_split: chunking, backpressure, enable gating,
// length changes and asynchronous reset, checked against hand-computed expectations.
module tb_axis_burst_split;
  localparam int WIDTH = 8;
  localparam int MAXLEN = 64;
  localparam int LBITS = $clog2(MAXLEN + 1);

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             enable_i = 1'b1;
  logic [LBITS-1:0] length_i = 7'd4;
  logic             busy_o, chunk_o;
  logic             s_tvalid = 1'b0;
  logic             s_tready;
  logic             s_tlast = 1'b0;
  logic [WIDTH-1:0] s_tdata = '0;
  logic             m_tvalid;
  logic             m_tready = 1'b0;
  logic             m_tlast, m_tend;
  logic [WIDTH-1:0] m_tdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int chunk_cnt = 0;
  bit rdy_fixed = 1'b1;
  bit rdy_rand = 1'b0;

  logic [7:0] out_d[$];
  bit         out_l[$];
  bit         out_e[$];
  int         out_c[$];
  int         acc_cyc[$];

  axis_burst_split #(.WIDTH(WIDTH), .MAXLEN(MAXLEN), .BYPASS(0)) dut (
    .clock(clock), .reset(reset), .enable_i(enable_i), .length_i(length_i),
    .busy_o(busy_o), .chunk_o(chunk_o),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tend(m_tend),
    .m_tdata(m_tdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #1;
    m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  // Output monitor: records every transferred beat and chunk_o pulse.
  always @(negedge clock) begin
    if (!reset) begin
      if (m_tvalid && m_tready) begin
        out_d.push_back(m_tdata);
        out_l.push_back(m_tlast);
        out_e.push_back(m_tend);
        out_c.push_back(cyc);
        $display("beat: data=%02h tlast=%0b tend=%0b cyc=%0d", m_tdata, m_tlast, m_tend, cyc);
      end
      if (chunk_o) chunk_cnt++;
    end
  end

  task automatic send(input int n, input int base);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < n && guard < 3000) begin
      s_tvalid = 1'b1;
      s_tdata  = 8'(base + i);
      s_tlast  = (i == n - 1);
      @(negedge clock);
      acc = s_tready;
      @(posedge clock);
      #1;
      if (acc) begin
        acc_cyc.push_back(cyc);
        acc_cnt++;
        i++;
      end
      guard++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    checks++;
    if (i < n) begin
      errors++;
      $display("FAIL send_timeout: accepted %0d beats, required %0d", i, n);
    end
  endtask

  task automatic wait_out(input int n);
    int g = 0;
    while (out_d.size() < n && g < 2000) begin
      @(posedge clock);
      #1;
      g++;
    end
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    checks++;
    if (out_d.size() != n) begin
      errors++;
      $display("FAIL beat_count: got %0d output beats, required %0d", out_d.size(), n);
    end
  endtask

  task automatic test_reset;
    @(negedge clock);
    checks++;
    if ({s_tready, m_tvalid, busy_o, chunk_o, m_tlast, m_tend} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: rdy/val/busy/chunk/last/end=%06b required 000000",
               {s_tready, m_tvalid, busy_o, chunk_o, m_tlast, m_tend});
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("FAIL release_ready_low: s_tready=%b required 0", s_tready);
    end
    @(negedge clock);
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready_high: s_tready=%b required 1", s_tready);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_split4;
    int base = out_d.size();
    int a0 = acc_cyc.size();
    int c0 = chunk_cnt;
    bit el, ee;
    length_i = 7'd4;
    send(10, 0);
    wait_out(base + 10);
    for (int i = 0; i < 10; i++) begin
      el = (i == 3) || (i == 7) || (i == 9);
      ee = (i == 9);
      checks++;
      if (out_d[base+i] !== 8'(i) || out_l[base+i] !== el || out_e[base+i] !== ee) begin
        errors++;
        $display("FAIL split4_beat%0d: data=%02h last=%0b end=%0b required data=%02h last=%0b end=%0b",
                 i, out_d[base+i], out_l[base+i], out_e[base+i], 8'(i), el, ee);
      end
      checks++;
      if (out_c[base+i] !== acc_cyc[a0+i]) begin
        errors++;
        $display("FAIL split4_latency%0d: out cycle=%0d required %0d", i, out_c[base+i], acc_cyc[a0+i]);
      end
    end
    checks++;
    if (chunk_cnt - c0 !== 3) begin
      errors++;
      $display("FAIL split4_chunk_pulses: got %0d required 3", chunk_cnt - c0);
    end
  endtask

  task automatic test_maxlen;
    int base = out_d.size();
    bit el, ee;
    length_i = 7'd0;
    send(70, 0);
    wait_out(base + 70);
    for (int i = 0; i < 70; i++) begin
      el = (i == 63) || (i == 69);
      ee = (i == 69);
      checks++;
      if (out_d[base+i] !== 8'(i) || out_l[base+i] !== el || out_e[base+i] !== ee) begin
        errors++;
        $display("FAIL maxlen_beat%0d: data=%02h last=%0b end=%0b required data=%02h last=%0b end=%0b",
                 i, out_d[base+i], out_l[base+i], out_e[base+i], 8'(i), el, ee);
      end
    end
  endtask

  task automatic test_backpressure;
    int base = out_d.size();
    bit el;
    length_i = 7'd3;
    rdy_rand = 1'b1;
    send(20, 8'h60);
    rdy_rand = 1'b0;
    rdy_fixed = 1'b1;
    wait_out(base + 20);
    for (int i = 0; i < 20; i++) begin
      el = (i % 3 == 2) || (i == 19);
      checks++;
      if (out_d[base+i] !== 8'(8'h60 + i) || out_l[base+i] !== el || out_e[base+i] !== (i == 19)) begin
        errors++;
        $display("FAIL bp_beat%0d: data=%02h last=%0b end=%0b required data=%02h last=%0b end=%0b",
                 i, out_d[base+i], out_l[base+i], out_e[base+i], 8'(8'h60 + i), el, (i == 19));
      end
    end
  endtask

  task automatic test_enable;
    int base = out_d.size();
    int a0 = acc_cnt;
    int hi = 0;
    int g = 0;
    length_i = 7'd4;
    fork
      send(8, 8'h20);
      begin
        while (acc_cnt - a0 < 1 && g < 200) begin
          @(posedge clock);
          #1;
          g++;
        end
        enable_i = 1'b0;
        repeat (4) begin
          @(posedge clock);
          #1;
        end
        for (int k = 0; k < 8; k++) begin
          @(negedge clock);
          if (s_tready) hi++;
          @(posedge clock);
          #1;
        end
        checks++;
        if (acc_cnt - a0 !== 4) begin
          errors++;
          $display("FAIL enable_chunk_done: accepted %0d beats while disabled, required 4", acc_cnt - a0);
        end
        checks++;
        if (hi !== 0) begin
          errors++;
          $display("FAIL enable_ready_low: s_tready high %0d cycles, required 0", hi);
        end
        enable_i = 1'b1;
      end
    join
    wait_out(base + 8);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_d[base+i] !== 8'(8'h20 + i) || out_l[base+i] !== (i == 3 || i == 7)) begin
        errors++;
        $display("FAIL enable_beat%0d: data=%02h last=%0b required data=%02h last=%0b",
                 i, out_d[base+i], out_l[base+i], 8'(8'h20 + i), (i == 3 || i == 7));
      end
    end
  endtask

  task automatic test_length_change;
    int base = out_d.size();
    int a0 = acc_cnt;
    int g = 0;
    bit el;
    length_i = 7'd4;
    fork
      send(10, 8'h50);
      begin
        while (acc_cnt - a0 < 2 && g < 200) begin
          @(posedge clock);
          #1;
          g++;
        end
        length_i = 7'd2;
      end
    join
    wait_out(base + 10);
    for (int i = 0; i < 10; i++) begin
      el = (i == 3) || (i == 5) || (i == 7) || (i == 9);
      checks++;
      if (out_d[base+i] !== 8'(8'h50 + i) || out_l[base+i] !== el) begin
        errors++;
        $display("FAIL lenchg_beat%0d: data=%02h last=%0b required data=%02h last=%0b",
                 i, out_d[base+i], out_l[base+i], 8'(8'h50 + i), el);
      end
    end
  endtask

  task automatic test_reset_mid_chunk;
    int base;
    rdy_fixed = 1'b0;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    base = out_d.size();
    length_i = 7'd4;
    s_tvalid = 1'b1;
    s_tdata  = 8'hA0;
    s_tlast  = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    checks++;
    if ({s_tready, m_tvalid, busy_o} !== 3'b011) begin
      errors++;
      $display("FAIL skid_full: rdy/val/busy=%03b required 011", {s_tready, m_tvalid, busy_o});
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({s_tready, m_tvalid, busy_o} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: rdy/val/busy=%03b required 000", {s_tready, m_tvalid, busy_o});
    end
    s_tvalid = 1'b0;
    rdy_fixed = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    send(6, 8'h40);
    wait_out(base + 6);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_d[base+i] !== 8'(8'h40 + i) || out_l[base+i] !== (i == 3 || i == 5) ||
          out_e[base+i] !== (i == 5)) begin
        errors++;
        $display("FAIL post_reset_beat%0d: data=%02h last=%0b end=%0b required data=%02h last=%0b end=%0b",
                 i, out_d[base+i], out_l[base+i], out_e[base+i], 8'(8'h40 + i),
                 (i == 3 || i == 5), (i == 5));
      end
    end
  endtask

  initial begin
    test_reset;
    test_split4;
    test_maxlen;
    test_backpressure;
    test_enable;
    test_length_change;
    test_reset_mid_chunk;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
